inst_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that supersedes the bare instruction memory. Owns the program counter, reads little-endian instruction words from an internal byte-addressed ROM, and presents `{pc, instr, next_pc}` to decode through a valid/ready handshake. Adds stall, redirect (branch/jump), and a sticky fetch-fault mode for misaligned or out-of-range PCs. Sits between the PC-redirect logic of execute and the decode stage.

---
 rtl/inst_fetch_unit_pkg.sv | 16 +
 rtl/inst_fetch_unit_rom.sv | 32 +++
 rtl/inst_fetch_unit.sv | 93 +++++++++
 tb/tb_inst_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch unit and its ROM.
package ifu_pkg;

  function automatic int unsigned ILEN_BYTES(input int unsigned ilen);
    return ilen / 8;
  endfunction

  typedef enum logic {
    IFU_RUN   = 1'b0,
    IFU_FAULT = 1'b1
  } ifu_state_e;

  // Wide enough for any realistic ILEN; sliced down at the point of use.
  localparam logic [255:0] FAULT_INSTR = '0;

endpackage

// File: rtl/inst_fetch_unit_rom.sv
// Byte-addressed instruction ROM with a combinational little-endian word read.
module inst_rom
  import ifu_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ILEN        = 32,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter string       INIT_FILE   = ""
) (
  input  logic [XLEN-1:0] addr_i,
  output logic [ILEN-1:0] data_o
);

  localparam int unsigned NB = ILEN_BYTES(ILEN);
  localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0] mem [DEPTH_BYTES];

  initial begin
    for (int i = 0; i < DEPTH_BYTES; i++) mem[i] = 8'h00;
  end

  // Range check is done one bit wider than XLEN so a wrapping byte address reads as 0.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < NB; k++) begin
      if (({1'b0, addr_i} + (XLEN+1)'(k)) < (XLEN+1)'(DEPTH_BYTES))
        data_o[8*k +: 8] = mem[AW'(addr_i + XLEN'(k))];
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, reads the ROM, and presents {pc, instr, next_pc} to decode.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned    XLEN        = 64,
  parameter int unsigned    ILEN        = 32,
  parameter int unsigned    DEPTH_BYTES = 256,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter string          INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_fault
);

  localparam int unsigned     NB   = ILEN_BYTES(ILEN);
  localparam logic [XLEN-1:0] STEP = XLEN'(NB);

  ifu_state_e      state_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic [XLEN-1:0] opc_q;
  logic [ILEN-1:0] instr_q;
  logic [XLEN-1:0] npc_q;
  logic            fault_q;

  logic [ILEN-1:0] instr_d;
  logic [XLEN:0]   end_addr;
  logic [XLEN-1:0] pc_inc;
  logic            fetch_fault;

  inst_rom #(
    .XLEN        (XLEN),
    .ILEN        (ILEN),
    .DEPTH_BYTES (DEPTH_BYTES),
    .INIT_FILE   (INIT_FILE)
  ) u_rom (
    .addr_i (pc_q),
    .data_o (instr_d)
  );

  // One extra bit keeps the end-of-word address exact even when pc_q is near 2^XLEN.
  assign end_addr    = {1'b0, pc_q} + {1'b0, STEP};
  assign pc_inc      = end_addr[XLEN-1:0];
  assign fetch_fault = ((pc_q % STEP) != '0) || (end_addr > (XLEN+1)'(DEPTH_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IFU_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      opc_q   <= '0;
      instr_q <= '0;
      npc_q   <= '0;
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      state_q <= IFU_RUN;
      pc_q    <= redirect_pc;
      valid_q <= 1'b0;
    end else if (!valid_q || out_ready) begin
      if (state_q == IFU_FAULT) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= 1'b1;
        opc_q   <= pc_q;
        npc_q   <= pc_inc;
        if (fetch_fault) begin
          instr_q <= FAULT_INSTR[ILEN-1:0];
          fault_q <= 1'b1;
          state_q <= IFU_FAULT;
        end else begin
          instr_q <= instr_d;
          fault_q <= 1'b0;
          pc_q    <= pc_inc;
        end
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = opc_q;
  assign out_instr   = instr_q;
  assign out_next_pc = npc_q;
  assign out_fault   = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios, a per-cycle reference model, and literal pins.
module tb_inst_fetch_unit;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [63:0] out_next_pc;
  logic        out_fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rom_img [DEPTH];

  inst_fetch_unit #(
    .XLEN        (64),
    .ILEN        (32),
    .DEPTH_BYTES (DEPTH),
    .RESET_PC    (64'h0),
    .INIT_FILE   ("")
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_next_pc    (out_next_pc),
    .out_fault      (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the presented entry plus the next PC to fetch and a halted flag.
  typedef struct packed {
    logic        v;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] npc;
    logic        f;
  } ent_t;

  ent_t        m_out;
  logic [63:0] m_pc;
  bit          m_halted;
  bit          m_in_rst;

  function automatic ent_t fetch_at(input logic [63:0] pc);
    ent_t e;
    int   base;
    e.v   = 1'b1;
    e.pc  = pc;
    e.npc = pc + 64'd4;
    e.f   = (pc % 64'd4 != 64'd0) || (pc > 64'(DEPTH - 4));
    if (e.f) begin
      e.instr = 32'h0;
    end else begin
      base    = int'(pc);
      e.instr = {rom_img[base+3], rom_img[base+2], rom_img[base+1], rom_img[base]};
    end
    return e;
  endfunction

  always @(posedge clk) begin
    m_in_rst = rst;
    if (rst) begin
      m_out    = '0;
      m_pc     = 64'h0;
      m_halted = 1'b0;
    end else if (redirect_valid) begin
      m_out.v  = 1'b0;
      m_pc     = redirect_pc;
      m_halted = 1'b0;
    end else if (!m_out.v || out_ready) begin
      if (m_halted) begin
        m_out.v = 1'b0;
      end else begin
        m_out = fetch_at(m_pc);
        if (m_out.f) m_halted = 1'b1;
        else m_pc = m_pc + 64'd4;
      end
    end
    #1;
    chk("model_valid", out_valid, m_out.v);
    if (m_out.v || m_in_rst) begin
      chk("model_pc", out_pc, m_out.pc);
      chk("model_instr", out_instr, m_out.instr);
      chk("model_next_pc", out_next_pc, m_out.npc);
      chk("model_fault", out_fault, m_out.f);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pin_entry(input string name, input logic [63:0] pc, input logic [31:0] instr,
                           input logic [63:0] npc, input logic f);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_pc"}, out_pc, pc);
    chk({name, "_instr"}, out_instr, instr);
    chk({name, "_next_pc"}, out_next_pc, npc);
    chk({name, "_fault"}, out_fault, f);
  endtask

  task automatic pin_zero(input string name);
    chk({name, "_valid"}, out_valid, 1'b0);
    chk({name, "_pc"}, out_pc, 64'h0);
    chk({name, "_instr"}, out_instr, 32'h0);
    chk({name, "_next_pc"}, out_next_pc, 64'h0);
    chk({name, "_fault"}, out_fault, 1'b0);
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    chk("redirect_flush_valid", out_valid, 1'b0);
    redirect_valid = 1'b0;
    step();
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b1;
    for (int i = 0; i < DEPTH; i++) rom_img[i] = 8'(i) ^ 8'h5A;
    rom_img[0] = 8'h13; rom_img[1] = 8'h05; rom_img[2] = 8'ha0; rom_img[3] = 8'h00;
    rom_img[4] = 8'h93; rom_img[5] = 8'h05; rom_img[6] = 8'hb0; rom_img[7] = 8'h00;
    #1;
    for (int i = 0; i < DEPTH; i++) dut.u_rom.mem[i] = rom_img[i];

    step();
    step();
    pin_zero("reset");

    // Sequential fetch
    rst = 1'b0;
    step();
    pin_entry("seq0", 64'h0, 32'h00a00513, 64'h4, 1'b0);
    step();
    pin_entry("seq1", 64'h4, 32'h00b00593, 64'h8, 1'b0);

    // Stall holds the entry at pc 4
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      pin_entry("stall", 64'h4, 32'h00b00593, 64'h8, 1'b0);
    end
    out_ready = 1'b1;
    step();
    pin_entry("after_stall", 64'h8, 32'h51505352, 64'hC, 1'b0);

    // Redirect while stalled at pc 8
    out_ready = 1'b0;
    redirect_to(64'h40);
    out_ready = 1'b1;
    pin_entry("redir40", 64'h40, 32'h19181B1A, 64'h44, 1'b0);

    // Misaligned fault, then recovery by redirect
    redirect_to(64'hA);
    pin_entry("misalign", 64'hA, 32'h0, 64'hE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fault_idle_valid", out_valid, 1'b0);
    end
    redirect_to(64'h10);
    pin_entry("resume10", 64'h10, 32'h49484B4A, 64'h14, 1'b0);

    // Last in-range word, then range fault at DEPTH
    redirect_to(64'(DEPTH - 4));
    pin_entry("last_word", 64'hFC, 32'hA5A4A7A6, 64'h100, 1'b0);
    step();
    pin_entry("range_fault", 64'h100, 32'h0, 64'h104, 1'b1);

    // Top-of-address-space fault with wrapped next_pc
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    pin_entry("wrap_fault", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 64'h0, 1'b1);

    // Reset while stalled in FAULT
    out_ready = 1'b0;
    step();
    pin_entry("fault_stall", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 64'h0, 1'b1);
    rst = 1'b1;
    step();
    pin_zero("reset_in_fault");
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    pin_entry("post_reset", 64'h0, 32'h00a00513, 64'h4, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
